// File: rtl/ram_arbiter_rr.sv
// Round-robin arbiter that hands a single-port RAM to one of N masters at a time,
// with an optional hold limit and a one-cycle turnaround gap between owners.
module ram_arbiter_rr #(
  parameter int N_MASTERS = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MAX_HOLD  = 16
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic [N_MASTERS-1:0]          Req,
  output logic [N_MASTERS-1:0]          Grant,
  output logic [$clog2(N_MASTERS)-1:0]  Owner,
  output logic                          Busy,
  output logic                          Preempt,
  input  logic [N_MASTERS*ADDR_W-1:0]   M_Address,
  input  logic [N_MASTERS*DATA_W-1:0]   M_DataOut,
  input  logic [N_MASTERS-1:0]          M_Cs,
  input  logic [N_MASTERS-1:0]          M_Wen,
  input  logic [N_MASTERS-1:0]          M_Oen,
  output logic [ADDR_W-1:0]             RAM_Address,
  output logic [DATA_W-1:0]             RAM_DataIn,
  output logic                          RAM_Cs,
  output logic                          RAM_Wen,
  output logic                          RAM_Oen
);

  localparam int OW = $clog2(N_MASTERS);
  localparam int CW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD);
  // The hold counter saturates at the limit, so a long solo owner is rotated
  // out as soon as a competitor shows up.
  localparam logic [CW-1:0] HOLD_LAST = CW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t                 state, state_nxt;
  logic [OW-1:0]          last, last_nxt, owner_nxt, winner, cand;
  logic [N_MASTERS-1:0]   grant_nxt, winner_mask, owner_mask;
  logic [CW-1:0]          hold_cnt, hold_nxt;
  logic                   preempt_nxt, any_req, other_req, hold_expired;
  logic [ADDR_W-1:0]      addr_q, mux_addr;
  logic [DATA_W-1:0]      data_q, mux_data;
  logic [ADDR_W-1:0]      addr_arr [N_MASTERS];
  logic [DATA_W-1:0]      data_arr [N_MASTERS];

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_unpack
    assign addr_arr[i] = M_Address[i*ADDR_W +: ADDR_W];
    assign data_arr[i] = M_DataOut[i*DATA_W +: DATA_W];
  end

  // Descending scan so the candidate closest after the last owner wins.
  always_comb begin
    winner = last;
    cand   = '0;
    for (int i = N_MASTERS; i >= 1; i--) begin
      cand = OW'((int'(last) + i) % N_MASTERS);
      if (Req[cand]) winner = cand;
    end
    winner_mask         = '0;
    winner_mask[winner] = 1'b1;
    owner_mask          = '0;
    owner_mask[Owner]   = 1'b1;
  end

  assign any_req      = |Req;
  assign other_req    = |(Req & ~owner_mask);
  assign hold_expired = (MAX_HOLD > 0) && (hold_cnt == HOLD_LAST) && other_req;

  always_comb begin
    state_nxt   = state;
    grant_nxt   = Grant;
    owner_nxt   = Owner;
    last_nxt    = last;
    hold_nxt    = hold_cnt;
    preempt_nxt = 1'b0;
    case (state)
      GRANT: begin
        if (hold_cnt != HOLD_LAST) hold_nxt = hold_cnt + CW'(1);
        if (!Req[Owner]) begin
          state_nxt = GAP;
          grant_nxt = '0;
        end else if (hold_expired) begin
          state_nxt   = GAP;
          grant_nxt   = '0;
          preempt_nxt = 1'b1;
        end
      end
      default: begin
        grant_nxt = '0;
        if (any_req) begin
          state_nxt = GRANT;
          grant_nxt = winner_mask;
          owner_nxt = winner;
          last_nxt  = winner;
          hold_nxt  = '0;
        end else begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= IDLE;
      Grant    <= '0;
      Owner    <= '0;
      last     <= OW'(N_MASTERS - 1);
      hold_cnt <= '0;
      Preempt  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state    <= state_nxt;
      Grant    <= grant_nxt;
      Owner    <= owner_nxt;
      last     <= last_nxt;
      hold_cnt <= hold_nxt;
      Preempt  <= preempt_nxt;
      if (state == GRANT) begin
        addr_q <= mux_addr;
        data_q <= mux_data;
      end
    end
  end

  // Address and data park on the last owner's values so the RAM pins stay quiet.
  assign Busy        = (state == GRANT);
  assign mux_addr    = addr_arr[Owner];
  assign mux_data    = data_arr[Owner];
  assign RAM_Address = Busy ? mux_addr : addr_q;
  assign RAM_DataIn  = Busy ? mux_data : data_q;
  assign RAM_Cs      = Busy & M_Cs[Owner];
  assign RAM_Wen     = ~Busy | M_Wen[Owner];
  assign RAM_Oen     = ~Busy | M_Oen[Owner];

endmodule

// File: doc/ram_arbiter_rr.md
Name: ram_arbiter_rr

Overview:
Parametrised N-master RAM bus arbiter, successor to the fixed two-master CPU/DMA arbiter in the ucontroller top. Masters such as CPU, DMA channels and future peripherals request the single-port RAM. The block grants ownership round-robin, with an optional hold limit that forces rotation, and inserts a one-cycle bus turnaround gap on every handover. It muxes the owner's address, data and strobes onto the RAM port; RAM read data goes to all masters directly and does not pass through this block.

Parameters:
N_MASTERS, 4, number of requesting masters (2..8)
ADDR_W, 8, RAM address width
DATA_W, 8, RAM data width
MAX_HOLD, 16, max consecutive GRANT cycles while another master waits; 0 = unlimited

Ports:
Clk  input  1  clock, all logic on rising edge
Rst  input  1  synchronous reset, active-high
Req  input  N_MASTERS  per-master bus request, level
Grant  output  N_MASTERS  one-hot or zero ownership, registered
Owner  output  $clog2(N_MASTERS)  index of current or last owner
Busy  output  1  high while in GRANT
Preempt  output  1  one-cycle pulse when a grant is removed by hold-limit expiry
M_Address  input  N_MASTERS*ADDR_W  packed per-master addresses; master i at [i*ADDR_W +: ADDR_W]
M_DataOut  input  N_MASTERS*DATA_W  packed per-master write data
M_Cs  input  N_MASTERS  per-master chip select, active-high
M_Wen  input  N_MASTERS  per-master write enable, active-low
M_Oen  input  N_MASTERS  per-master output enable, active-low
RAM_Address  output  ADDR_W  to RAM
RAM_DataIn  output  DATA_W  to RAM
RAM_Cs  output  1  to RAM, active-high
RAM_Wen  output  1  to RAM, active-low
RAM_Oen  output  1  to RAM, active-low

Behaviour:
- Reset: one clock, synchronous, active-high (Rst). During and after reset:
  - state IDLE, Grant=0, Owner=0, Busy=0, Preempt=0, hold counter=0.
  - RR pointer last=N_MASTERS-1, so master 0 has top priority first.
  - RAM_Cs=0, RAM_Wen=1, RAM_Oen=1, RAM_Address=0, RAM_DataIn=0.
- Reset asserted mid-GRANT drops Grant and RAM strobes in the cycle after the reset edge. In-flight accesses are abandoned.
- States:
  - IDLE: no grant.
  - GRANT: exactly one Grant bit high.
  - GAP: turnaround, no grant.
- Arbitration function: first i with Req[i]=1, searching (last+1) mod N, (last+2) mod N, and so on.
- IDLE: if any Req, move to GRANT on the next edge and set Grant[winner], Owner=winner, last=winner, counter=0. Latency is Req high at edge k, Grant high after edge k+1's cycle start; Grant is a registered output, one cycle after Req is sampled.
- GRANT:
  - counter increments each cycle and saturates.
  - Go to GAP if Req[Owner]=0.
  - Also go to GAP if MAX_HOLD>0, counter==MAX_HOLD-1, and any other Req is high. This path also pulses Preempt for one cycle, coincident with the first GAP cycle.
  - A preempted owner keeping Req high is simply re-arbitrated in RR order.
  - Owner dropping Req on the same cycle the hold limit expires: go to GAP with no Preempt pulse.
- GAP: lasts exactly one cycle, Grant=0, Busy=0. On the next edge: any Req leads to GRANT with the RR winner, otherwise IDLE. Owner holds the last value.
- RAM mux:
  - In GRANT: RAM_* is combinational from M_*[Owner].
  - Outside GRANT: strobes are forced inactive (Cs=0, Wen=1, Oen=1) and Address/DataIn are held at their last value.
  - No strobes pass in GAP even if a master drives them.
- Single requester: it keeps the grant indefinitely. The hold limit applies only when another master waits.
- Req from a waiting master that drops before it is granted is ignored; there is no latched request.
- Grant is never multi-hot. There is never a GRANT-to-GRANT transition without an intervening GAP.

Test Plan:
- Reset, then Req=4'b0001 → Grant=0001 one cycle later, Busy=1. Drive M_Address[0]=8'h3C, M_Cs[0]=1, M_Wen[0]=0 → RAM_Address=3C, RAM_Cs=1, RAM_Wen=0 in the same cycle.
- Req=4'b1111 held, MAX_HOLD=4 → grant sequence 0,1,2,3,0. Each grant lasts 4 cycles, separated by 1-cycle GAPs. Preempt pulses at each of the 4 handovers.
- Owner 2 drops Req while Req[1] is high, last=2 → GAP (RAM_Cs=0 despite M_Cs[1]=1), then Grant=0010. No Preempt.
- Single master 3 holds Req for 100 cycles with MAX_HOLD=4 → Grant=1000 throughout, no GAP, no Preempt.
- Rst=1 pulsed during a GRANT to master 1 → next cycle Grant=0, RAM_Cs=0, RAM_Wen=1, Owner=0. With Req=0011 still high, master 0 is granted first after reset.
- MAX_HOLD=0 with Req=0011 held → master 0 keeps the grant for the full 200-cycle run and master 1 is never granted.
